// File: rtl/axis_dlm_pkg.sv
// Shared types and helpers for the parametrised AXIS deadlock monitor.
package axis_dlm_pkg;

  // One-hot monitor FSM states.
  typedef enum logic [6:0] {
    ST_STARTUP     = 7'b0000001,
    ST_IDLE        = 7'b0000010,
    ST_ARM         = 7'b0000100,
    ST_COLLECT_DST = 7'b0001000,
    ST_COLLECT_SRC = 7'b0010000,
    ST_DONE        = 7'b0100000,
    ST_HOLD        = 7'b1000000
  } dlm_state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axis_dlm_sat_counter.sv
// Generic up-counter that sticks at all-ones; clear beats enable.
module axis_dlm_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, hold at the maximum, clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/axis_deadlock_monitor_param.sv
// Per-kernel deadlock monitor: declares deadlock after a run of blocked
// cycles and captures which ports were starved (dst) and blocking (src).
module axis_deadlock_monitor_param
  import axis_dlm_pkg::*;
#(
  parameter int NUM_AXIS       = 2,
  parameter int NUM_INST       = 1,
  parameter int STARTUP_CYCLES = 10,
  parameter int BLOCK_THRESH   = 2,
  parameter int CNT_W          = 16
) (
  input  logic                kernel_monitor_clock,
  input  logic                kernel_monitor_reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_AXIS-1:0] axis_is_out,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                deadlock,
  output logic                rpt_valid,
  output logic [NUM_AXIS-1:0] rpt_dst,
  output logic [NUM_AXIS-1:0] rpt_src,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int RUN_W = cnt_width(BLOCK_THRESH);
  localparam int SU_W  = cnt_width(STARTUP_CYCLES);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(BLOCK_THRESH);
  localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(STARTUP_CYCLES - 1);

  dlm_state_t           state_reg, state_next;
  logic [SU_W-1:0]      startup_cnt_reg, startup_cnt_next;
  logic [RUN_W-1:0]     run_cnt_reg, run_cnt_next, run_inc;
  logic                 block_reg;
  logic                 deadlock_reg, deadlock_next;
  logic                 rpt_valid_reg, rpt_valid_next;
  logic [NUM_AXIS-1:0]  rpt_dst_reg, rpt_dst_next;
  logic [NUM_AXIS-1:0]  rpt_src_reg, rpt_src_next;
  logic                 raw_block;

  // Direction is only meaningful to whoever decodes the report.
  logic unused_axis_is_out;
  assign unused_axis_is_out = ^axis_is_out;

  // Kernel counts as blocked only if something blocks and not everyone is idle.
  assign raw_block = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);

  // State and report registers; reset aborts everything immediately.
  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      state_reg       <= ST_STARTUP;
      startup_cnt_reg <= '0;
      run_cnt_reg     <= '0;
      block_reg       <= 1'b0;
      deadlock_reg    <= 1'b0;
      rpt_valid_reg   <= 1'b0;
      rpt_dst_reg     <= '0;
      rpt_src_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      startup_cnt_reg <= startup_cnt_next;
      run_cnt_reg     <= run_cnt_next;
      block_reg       <= raw_block;
      deadlock_reg    <= deadlock_next;
      rpt_valid_reg   <= rpt_valid_next;
      rpt_dst_reg     <= rpt_dst_next;
      rpt_src_reg     <= rpt_src_next;
    end
  end

  // Next-state logic; clear outside STARTUP overrides every state action.
  always_comb begin
    state_next       = state_reg;
    startup_cnt_next = startup_cnt_reg;
    run_cnt_next     = run_cnt_reg;
    deadlock_next    = deadlock_reg;
    rpt_valid_next   = 1'b0;
    rpt_dst_next     = rpt_dst_reg;
    rpt_src_next     = rpt_src_reg;
    run_inc          = run_cnt_reg + RUN_W'(1);

    if (clear && (state_reg != ST_STARTUP)) begin
      state_next    = ST_IDLE;
      run_cnt_next  = '0;
      deadlock_next = 1'b0;
      rpt_dst_next  = '0;
      rpt_src_next  = '0;
    end else begin
      unique case (state_reg)
        ST_STARTUP: begin
          if (startup_cnt_reg == SU_LAST) begin
            state_next = ST_IDLE;
          end else begin
            startup_cnt_next = startup_cnt_reg + SU_W'(1);
          end
        end
        ST_IDLE: begin
          if (block_reg) begin
            if (BLOCK_THRESH == 1) begin
              state_next = ST_COLLECT_DST;
            end else begin
              state_next   = ST_ARM;
              run_cnt_next = RUN_W'(1);
            end
          end
        end
        ST_ARM: begin
          if (!block_reg) begin
            state_next   = ST_IDLE;
            run_cnt_next = '0;
          end else if (run_inc == RUN_LAST) begin
            state_next   = ST_COLLECT_DST;
            run_cnt_next = '0;
          end else begin
            run_cnt_next = run_inc;
          end
        end
        ST_COLLECT_DST: begin
          rpt_dst_next = ~axis_block_sigs;
          state_next   = ST_COLLECT_SRC;
        end
        ST_COLLECT_SRC: begin
          rpt_src_next = axis_block_sigs;
          state_next   = ST_DONE;
        end
        ST_DONE: begin
          rpt_valid_next = 1'b1;
          deadlock_next  = 1'b1;
          state_next     = ST_HOLD;
        end
        ST_HOLD: begin
          state_next = ST_HOLD;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  axis_dlm_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (kernel_monitor_clock),
    .rst   (kernel_monitor_reset),
    .clr   (clear),
    .en    (block_reg),
    .count (stall_cnt)
  );

  assign block     = block_reg;
  assign deadlock  = deadlock_reg;
  assign rpt_valid = rpt_valid_reg;
  assign rpt_dst   = rpt_dst_reg;
  assign rpt_src   = rpt_src_reg;

endmodule

// File: tb/tb_axis_deadlock_monitor_param.sv
// Self-checking bench for axis_deadlock_monitor_param with an edge-indexed
// event model of startup gating, run detection, snapshot and clear.
module tb_axis_deadlock_monitor_param;

  localparam int NA   = 4;
  localparam int NI   = 2;
  localparam int SU   = 10;
  localparam int BT   = 4;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NA-1:0] axis_block_sigs = '0;
  logic [NA-1:0] axis_is_out = 4'b1100;
  logic [NI-1:0] inst_idle_sigs = '0;
  logic [NI-1:0] inst_block_sigs = '0;
  logic          clear = 1'b0;
  logic          block, deadlock, rpt_valid;
  logic [NA-1:0] rpt_dst, rpt_src;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: edge index since reset release plus pending-report events.
  int            m_edge, m_run, m_det, m_stall;
  bit            m_done, m_blk, m_deadlock, m_rv;
  logic [NA-1:0] m_dst, m_src;

  axis_deadlock_monitor_param #(
    .NUM_AXIS(NA), .NUM_INST(NI), .STARTUP_CYCLES(SU),
    .BLOCK_THRESH(BT), .CNT_W(CW)
  ) dut (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst),
    .axis_block_sigs      (axis_block_sigs),
    .axis_is_out          (axis_is_out),
    .inst_idle_sigs       (inst_idle_sigs),
    .inst_block_sigs      (inst_block_sigs),
    .clear                (clear),
    .block                (block),
    .deadlock             (deadlock),
    .rpt_valid            (rpt_valid),
    .rpt_dst              (rpt_dst),
    .rpt_src              (rpt_src),
    .stall_cnt            (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_edge = 0; m_run = 0; m_det = -1; m_stall = 0;
    m_done = 0; m_blk = 0; m_deadlock = 0; m_rv = 0;
    m_dst = '0; m_src = '0;
  endtask

  // Apply inputs for one clock edge, advance the model, sample 1 ns after the edge.
  task automatic step(input logic [NA-1:0] a, input logic [NI-1:0] idl,
                      input logic [NI-1:0] ib, input logic clr);
    bit prev_blk;
    axis_block_sigs = a; inst_idle_sigs = idl; inst_block_sigs = ib; clear = clr;
    m_edge++;
    prev_blk = m_blk;
    m_rv = 0;
    if (clr) m_stall = 0;
    else if (prev_blk && m_stall < MAXC) m_stall++;
    if (m_edge > SU) begin
      if (clr) begin
        m_run = 0; m_det = -1; m_done = 0; m_deadlock = 0; m_dst = '0; m_src = '0;
      end else if (m_det < 0 && !m_done) begin
        if (prev_blk) begin
          m_run++;
          if (m_run >= BT) begin m_det = m_edge; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end else if (m_det >= 0) begin
        if (m_edge == m_det + 1) m_dst = ~a;
        else if (m_edge == m_det + 2) m_src = a;
        else if (m_edge == m_det + 3) begin
          m_rv = 1; m_deadlock = 1; m_det = -1; m_done = 1;
        end
      end
    end
    m_blk = ((|a) || (|ib)) && !(&idl);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0; clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({block, deadlock, rpt_valid, rpt_dst, rpt_src, stall_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got blk=%b dl=%b rv=%b dst=%b src=%b cnt=%0d want all 0",
               block, deadlock, rpt_valid, rpt_dst, rpt_src, stall_cnt);
    end
    $display("test_reset: outputs sampled under reset");
  endtask

  task automatic test_startup();
    int found = -1;
    do_reset();
    for (int n = 1; n <= 40 && found < 0; n++) begin
      step(4'b1111, 2'b00, 2'b00, 1'b0);
      if (rpt_valid === 1'b1) found = n;
    end
    checks++;
    if (found != SU + BT + 3) begin
      failures++;
      $display("FAIL startup_report_edge got %0d want %0d", found, SU + BT + 3);
    end
    checks++;
    if (deadlock !== 1'b1 || rpt_dst !== 4'b0000 || rpt_src !== 4'b1111) begin
      failures++;
      $display("FAIL startup_snapshot got dl=%b dst=%b src=%b want dl=1 dst=0000 src=1111",
               deadlock, rpt_dst, rpt_src);
    end
    checks++;
    if (stall_cnt !== CW'(MAXC)) begin
      failures++;
      $display("FAIL startup_stall got %0d want %0d", stall_cnt, MAXC);
    end
    step(4'b1111, 2'b00, 2'b00, 1'b0);
    checks++;
    if (rpt_valid !== 1'b0 || deadlock !== 1'b1) begin
      failures++;
      $display("FAIL startup_pulse_width got rv=%b dl=%b want rv=0 dl=1", rpt_valid, deadlock);
    end
    $display("test_startup: report at edge %0d", found);
  endtask

  task automatic test_glitch();
    int rv_seen = 0;
    int found = -1;
    do_reset();
    repeat (SU + 2) step(4'b0000, 2'b00, 2'b00, 1'b0);
    repeat (BT - 1) step(4'b0001, 2'b00, 2'b00, 1'b0);
    repeat (5) begin
      step(4'b0000, 2'b00, 2'b00, 1'b0);
      if (rpt_valid === 1'b1) rv_seen++;
    end
    checks++;
    if (deadlock !== 1'b0 || rv_seen != 0 || stall_cnt !== CW'(BT - 1)) begin
      failures++;
      $display("FAIL glitch_reject got dl=%b rv_seen=%0d cnt=%0d want dl=0 rv_seen=0 cnt=%0d",
               deadlock, rv_seen, stall_cnt, BT - 1);
    end
    // Back in IDLE: a full-length run must report with the idle-start latency.
    for (int n = 1; n <= 20 && found < 0; n++) begin
      step(4'b0001, 2'b00, 2'b00, 1'b0);
      if (rpt_valid === 1'b1) found = n;
    end
    checks++;
    if (found != BT + 4) begin
      failures++;
      $display("FAIL glitch_rearm_latency got %0d want %0d", found, BT + 4);
    end
    $display("test_glitch: rearm report after %0d cycles", found);
  endtask

  task automatic test_snapshot();
    int found = -1;
    do_reset();
    repeat (SU + 2) step(4'b0000, 2'b00, 2'b00, 1'b0);
    for (int n = 1; n <= 20 && found < 0; n++) begin
      step(4'b0101, 2'b00, 2'b00, 1'b0);
      if (rpt_valid === 1'b1) found = n;
    end
    checks++;
    if (found < 0 || rpt_src !== 4'b0101 || rpt_dst !== 4'b1010) begin
      failures++;
      $display("FAIL snapshot got found=%0d src=%b dst=%b want src=0101 dst=1010",
               found, rpt_src, rpt_dst);
    end
    step(4'b0101, 2'b00, 2'b00, 1'b0);
    checks++;
    if (rpt_valid !== 1'b0) begin
      failures++;
      $display("FAIL snapshot_pulse got rv=%b want 0", rpt_valid);
    end
    $display("test_snapshot: src=%b dst=%b", rpt_src, rpt_dst);
  endtask

  task automatic test_idle_mask();
    int found = -1;
    int blk_seen = 0;
    do_reset();
    repeat (SU + 2) step(4'b0000, 2'b11, 2'b00, 1'b0);
    repeat (15) begin
      step(4'b1111, 2'b11, 2'b11, 1'b0);
      if (block !== 1'b0) blk_seen++;
    end
    checks++;
    if (blk_seen != 0 || deadlock !== 1'b0 || stall_cnt !== '0) begin
      failures++;
      $display("FAIL idle_mask got blk_seen=%0d dl=%b cnt=%0d want 0 0 0",
               blk_seen, deadlock, stall_cnt);
    end
    for (int n = 1; n <= 20 && found < 0; n++) begin
      step(4'b1111, 2'b10, 2'b11, 1'b0);
      if (rpt_valid === 1'b1) found = n;
    end
    checks++;
    if (found != BT + 4 || deadlock !== 1'b1) begin
      failures++;
      $display("FAIL idle_unmask got found=%0d dl=%b want found=%0d dl=1", found, deadlock, BT + 4);
    end
    $display("test_idle_mask: report after %0d cycles once unmasked", found);
  endtask

  task automatic test_clear_priority();
    int found = -1;
    int guard = 0;
    do_reset();
    repeat (SU + 2) step(4'b0000, 2'b00, 2'b00, 1'b0);
    while (!(m_det >= 0 && m_edge + 1 == m_det + 3) && guard < 30) begin
      step(4'b0011, 2'b00, 2'b00, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 30) begin
      failures++;
      $display("FAIL clear_setup got guard=%0d want <30", guard);
    end
    step(4'b0011, 2'b00, 2'b00, 1'b1);
    checks++;
    if (rpt_valid !== 1'b0 || deadlock !== 1'b0 || stall_cnt !== '0 ||
        rpt_dst !== '0 || rpt_src !== '0) begin
      failures++;
      $display("FAIL clear_in_done got rv=%b dl=%b cnt=%0d dst=%b src=%b want all 0",
               rpt_valid, deadlock, stall_cnt, rpt_dst, rpt_src);
    end
    for (int n = 1; n <= 20 && found < 0; n++) begin
      step(4'b0011, 2'b00, 2'b00, 1'b0);
      if (rpt_valid === 1'b1) found = n;
    end
    checks++;
    if (found != BT + 3 || rpt_src !== 4'b0011 || rpt_dst !== 4'b1100) begin
      failures++;
      $display("FAIL clear_rereport got found=%0d src=%b dst=%b want found=%0d src=0011 dst=1100",
               found, rpt_src, rpt_dst, BT + 3);
    end
    $display("test_clear_priority: new report %0d cycles after clear", found);
  endtask

  task automatic test_saturation_async_reset();
    do_reset();
    repeat (SU + 2) step(4'b0000, 2'b00, 2'b00, 1'b0);
    step(4'b0000, 2'b00, 2'b00, 1'b1);
    repeat (20) step(4'b1000, 2'b00, 2'b00, 1'b0);
    checks++;
    if (stall_cnt !== CW'(MAXC) || deadlock !== 1'b1) begin
      failures++;
      $display("FAIL saturation got cnt=%0d dl=%b want cnt=%0d dl=1", stall_cnt, deadlock, MAXC);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({block, deadlock, rpt_valid, rpt_dst, rpt_src, stall_cnt} !== '0) begin
      failures++;
      $display("FAIL async_reset got blk=%b dl=%b rv=%b dst=%b src=%b cnt=%0d want all 0",
               block, deadlock, rpt_valid, rpt_dst, rpt_src, stall_cnt);
    end
    $display("test_saturation_async_reset: cnt held at %0d before reset", MAXC);
    do_reset();
  endtask

  task automatic test_random();
    int errs_before = failures;
    logic [NA-1:0] a;
    logic [NI-1:0] idl, ib;
    logic clr;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      a   = ($urandom_range(0, 3) == 0) ? '0 : NA'($urandom);
      idl = ($urandom_range(0, 7) == 0) ? '1 : NI'($urandom_range(0, 2));
      ib  = NI'($urandom);
      clr = ($urandom_range(0, 29) == 0);
      step(a, idl, ib, clr);
      checks++;
      if (block !== m_blk || deadlock !== m_deadlock || rpt_valid !== m_rv) begin
        failures++;
        $display("FAIL random_flags edge=%0d got blk=%b dl=%b rv=%b want blk=%b dl=%b rv=%b",
                 m_edge, block, deadlock, rpt_valid, m_blk, m_deadlock, m_rv);
      end
      checks++;
      if (rpt_dst !== m_dst || rpt_src !== m_src || stall_cnt !== CW'(m_stall)) begin
        failures++;
        $display("FAIL random_report edge=%0d got dst=%b src=%b cnt=%0d want dst=%b src=%b cnt=%0d",
                 m_edge, rpt_dst, rpt_src, stall_cnt, m_dst, m_src, m_stall);
      end
    end
    $display("test_random: 500 cycles, %0d new failures", failures - errs_before);
  endtask

  initial begin
    test_reset();
    test_startup();
    test_glitch();
    test_snapshot();
    test_idle_mask();
    test_clear_priority();
    test_saturation_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_deadlock_monitor_param.md
Name: axis_deadlock_monitor_param

Overview:
- Parametrised successor to the per-kernel AXIS deadlock monitor.
- Watches NUM_AXIS stream-port block signals and NUM_INST sub-instance idle/block signals.
- Declares a kernel deadlock after a programmable run of consecutive blocked cycles, then captures a synthesizable snapshot of starved ports (dst) and blocking ports (src).
- Sits beside each kernel instance in the simulation/debug top, one instance per kernel. Replaces the fixed two-port, simulation-only reporting.

Parameters:
- NUM_AXIS, 2, number of monitored AXIS ports (>=1).
- NUM_INST, 1, number of monitored sub-instances (>=1).
- STARTUP_CYCLES, 10, cycles after reset release before monitoring starts (>=1).
- BLOCK_THRESH, 2, consecutive blocked cycles required to declare deadlock (>=1).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- kernel_monitor_clock  in  1  sole clock, rising edge.
- kernel_monitor_reset  in  1  asynchronous, active-high reset.
- axis_block_sigs  in  NUM_AXIS  1 = port blocked externally (no input data / output not ready).
- axis_is_out  in  NUM_AXIS  static per-port direction, 1 = write port, 0 = read port.
- inst_idle_sigs  in  NUM_INST  1 = sub-instance idle.
- inst_block_sigs  in  NUM_INST  1 = sub-instance blocked.
- clear  in  1  synchronous clear of sticky report state and counter.
- block  out  1  registered kernel-block indication.
- deadlock  out  1  sticky deadlock flag.
- rpt_valid  out  1  one-cycle pulse when the snapshot completes.
- rpt_dst  out  NUM_AXIS  ports not externally blocked at capture (~axis_block_sigs).
- rpt_src  out  NUM_AXIS  ports externally blocked at capture (axis_block_sigs).
- stall_cnt  out  CNT_W  total cycles with block=1 since reset/clear, saturating.

Behaviour:
- Reset: all outputs 0, all registers 0, FSM enters STARTUP. Assertion mid-operation aborts any state immediately.
- raw_block = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs).
- block <= raw_block every cycle; 1-cycle latency. Updates in every state, including STARTUP.
- stall_cnt increments on each cycle with block=1. Holds at 2^CNT_W-1. Cleared to 0 by clear, and clear wins over a same-cycle increment.
- FSM states: STARTUP, IDLE, ARM, COLLECT_DST, COLLECT_SRC, DONE, HOLD.
- STARTUP: counts STARTUP_CYCLES cycles, then goes to IDLE. block is ignored for arming.
- IDLE: if block=1, go to ARM with run counter = 1. If BLOCK_THRESH=1, go straight to COLLECT_DST.
- ARM: if block=0, go to IDLE. Otherwise increment the run counter; on reaching BLOCK_THRESH go to COLLECT_DST.
- COLLECT_DST: rpt_dst <= ~axis_block_sigs; go to COLLECT_SRC.
- COLLECT_SRC: rpt_src <= axis_block_sigs; go to DONE. The two samples are taken one cycle apart, by design.
- DONE: rpt_valid=1 for this cycle only; deadlock <= 1; go to HOLD.
- HOLD: stays here, so only the first deadlock is reported until clear. block and stall_cnt keep running.
- clear (any state other than STARTUP): FSM goes to IDLE; deadlock, rpt_dst, rpt_src, run counter and stall_cnt go to 0.
- clear in DONE: suppresses rpt_valid and the deadlock set; clear has priority.
- clear during STARTUP: ignored for the FSM, but stall_cnt is still cleared.
- axis_is_out is not used in the decision logic. It is carried only for the report decoder/bench, which maps dst/src to "cannot be read/written" and "no valid input/not ready".
- Width rules: run counter is $clog2(BLOCK_THRESH+1) bits; startup counter is $clog2(STARTUP_CYCLES+1) bits.

Decomposition:
- Package axis_dlm_pkg holds the FSM state enum (one-hot, 7 states) and a helper function for counter widths.
- Sub-module axis_dlm_sat_counter: generic saturating counter with clear and enable, used for stall_cnt.
- Run and startup counters are inline.

Test Plan:
- Startup gating: reset, then axis_block_sigs=2'b11 from cycle 0 -> no ARM before cycle 10; rpt_valid pulses at cycle 10+1+2+2 (exact cycle checked); deadlock=1.
- Glitch rejection: BLOCK_THRESH=4, block high 3 cycles then low -> deadlock stays 0, FSM back in IDLE, stall_cnt=3.
- Snapshot: NUM_AXIS=4, axis_block_sigs=4'b0101 held -> rpt_src=4'b0101, rpt_dst=4'b1010, single-cycle rpt_valid.
- Idle masking: inst_idle_sigs all 1 with axis blocks asserted -> block=0, no deadlock. Drop one idle bit -> deadlock after the threshold.
- Clear priority: assert clear in the DONE cycle -> rpt_valid=0, deadlock=0, stall_cnt=0, FSM in IDLE. Re-block -> new report.
- Saturation and async reset: CNT_W=3, block held 20 cycles -> stall_cnt=7. Assert reset mid-HOLD asynchronously -> all outputs 0 before the next edge.
